// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round count, round-constant rules and sequencer states.
package aes_pkg;

    localparam int unsigned AES_NR    = 10;
    localparam logic [7:0]  RCON_INIT = 8'h01;
    localparam logic [7:0]  RCON_POLY = 8'h1b;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} ks_state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] next_rcon(input logic [7:0] rcon);
        return {rcon[6:0], 1'b0} ^ (rcon[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/rk_store_11x128.sv
// Round-key store: one synchronous write port, asynchronous read, out-of-range reads return zero.
module rk_store_11x128
    import aes_pkg::*;
#(
    parameter int unsigned Depth = AES_NR + 1,
    parameter int unsigned Width = 128,
    parameter int unsigned AddrW = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [Width-1:0] wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (raddr < AddrW'(Depth)) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/key_sched_ctrl_128.sv
// AES-128 key-expansion sequencer: drives the external round expander, captures each round key
// into a local store and flags when a complete schedule is available.
module key_sched_ctrl_128
    import aes_pkg::*;
#(
    parameter int unsigned NR      = AES_NR,
    parameter int unsigned EXP_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_vld,
    output logic [127:0] exp_in,
    output logic [7:0]   exp_rcon,
    input  logic [127:0] exp_out,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data
);

    localparam int unsigned CntW = (EXP_LAT > 1) ? $clog2(EXP_LAT) : 1;

    ks_state_e       state_q, state_d;
    logic [3:0]      round_q, round_d;
    logic [CntW-1:0] wcnt_q, wcnt_d;
    logic [127:0]    exp_in_q, exp_in_d;
    logic [7:0]      rcon_q, rcon_d;
    logic            keys_vld_q, keys_vld_d;

    logic            accept, wait_last, capture;
    logic            st_we;
    logic [3:0]      st_waddr;
    logic [127:0]    st_wdata;

    assign wait_last = (wcnt_q == CntW'(EXP_LAT - 1));
    assign accept    = (state_q == S_IDLE) && start;
    assign capture   = (state_q == S_WAIT) && wait_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (wait_last) begin
                    state_d = (round_q == 4'(NR)) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        st_we    = accept || capture;
        st_waddr = accept ? 4'd0 : round_q;
        st_wdata = accept ? key_in : exp_out;
    end

    // Datapath next state; start is only honoured from IDLE, so key_in is ignored while busy.
    always_comb begin
        round_d    = round_q;
        wcnt_d     = wcnt_q;
        exp_in_d   = exp_in_q;
        rcon_d     = rcon_q;
        keys_vld_d = keys_vld_q;
        if (accept) begin
            exp_in_d   = key_in;
            rcon_d     = RCON_INIT;
            round_d    = 4'd1;
            keys_vld_d = 1'b0;
        end
        if (state_q == S_ISSUE) begin
            wcnt_d = '0;
        end
        if ((state_q == S_WAIT) && !wait_last) begin
            wcnt_d = wcnt_q + 1'b1;
        end
        if (capture) begin
            exp_in_d = exp_out;
            rcon_d   = next_rcon(rcon_q);
            if (round_q != 4'(NR)) begin
                round_d = round_q + 4'd1;
            end
        end
        if (state_q == S_DONE) begin
            keys_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_q    <= '0;
            wcnt_q     <= '0;
            exp_in_q   <= '0;
            rcon_q     <= '0;
            keys_vld_q <= 1'b0;
        end else begin
            round_q    <= round_d;
            wcnt_q     <= wcnt_d;
            exp_in_q   <= exp_in_d;
            rcon_q     <= rcon_d;
            keys_vld_q <= keys_vld_d;
        end
    end

    assign exp_in   = exp_in_q;
    assign exp_rcon = rcon_q;
    assign keys_vld = keys_vld_q;

    rk_store_11x128 #(
        .Depth(NR + 1),
        .Width(128),
        .AddrW(4)
    ) u_store (
        .clk  (clk),
        .we   (st_we),
        .waddr(st_waddr),
        .wdata(st_wdata),
        .raddr(rk_addr),
        .rdata(rk_data)
    );

endmodule

// File: tb/tb_key_sched_ctrl_128.sv
// Bench for key_sched_ctrl_128: golden AES-128 expander attached to the DUT, scoreboard of
// expected schedules popped on each done pulse, per-cycle busy/done/keys_vld timeline model.
`timescale 1ns/10ps
module tb_key_sched_ctrl_128;

    localparam int EXP_LAT = 1;
    localparam int LAT     = 1 + 10 * (1 + EXP_LAT);

    typedef logic [10:0][127:0] sched_t;
    typedef struct {
        sched_t       sched;
        int           start_cyc;
        bit           kat;
        logic [127:0] kat1;
        logic [127:0] kat10;
    } exp_t;

    logic         clk, rst_n, start, busy, done, keys_vld;
    logic [127:0] key_in, exp_in, exp_out, rk_data;
    logic [7:0]   exp_rcon;
    logic [3:0]   rk_addr;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    exp_t         sb[$];
    logic [7:0]   tr_rcon[$];
    logic [127:0] tr_key[$];
    logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // Timeline model of the sequencer as seen from outside.
    bit have_s = 0;
    int s_cyc  = 0;
    bit kv_exp = 0;

    logic [127:0] pipe [EXP_LAT];

    key_sched_ctrl_128 #(.NR(10), .EXP_LAT(EXP_LAT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .key_in  (key_in),
        .busy    (busy),
        .done    (done),
        .keys_vld(keys_vld),
        .exp_in  (exp_in),
        .exp_rcon(exp_rcon),
        .exp_out (exp_out),
        .rk_addr (rk_addr),
        .rk_data (rk_data)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r  = 8'h01;
        logic [7:0] bb = x;
        logic [7:0] e  = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, bb);
            bb = gmul(bb, bb);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [31:0] subrot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    // One expansion round, as the external expander computes it.
    function automatic logic [127:0] expand_round(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ subrot(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Whole schedule in FIPS-197 word form with the tabulated round constants.
    function automatic sched_t ref_sched(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        sched_t s;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) t = subrot(t) ^ {rcon_tab[i / 4 - 1], 24'h0};
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) s[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        return s;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= expand_round(exp_in, exp_rcon);
        for (int i = 1; i < EXP_LAT; i++) pipe[i] <= pipe[i - 1];
    end
    assign exp_out = pipe[EXP_LAT - 1];

    // Monitor: per-cycle timeline checks, rcon/key trace, schedule readback on done.
    initial begin
        exp_t e;
        bit eb, ed;
        int c;
        rk_addr = 4'd0;
        forever begin
            @(negedge clk);
            c  = cyc;
            eb = have_s && (c >= s_cyc + 1) && (c <= s_cyc + LAT);
            ed = have_s && (c == s_cyc + LAT);
            check("busy", 128'(busy), 128'(eb));
            check("done", 128'(done), 128'(ed));
            check("keys_vld", 128'(keys_vld), 128'(kv_exp));
            if (eb && !ed && (tr_rcon.size() == 0 || exp_rcon != tr_rcon[$])) begin
                tr_rcon.push_back(exp_rcon);
                tr_key.push_back(exp_in);
            end
            if (ed) begin
                if (sb.size() == 0) begin
                    check("sb_empty_at_done", 128'(1), 128'(0));
                end else begin
                    e = sb.pop_front();
                    check("latency", 128'(c - e.start_cyc), 128'(LAT));
                    check("rcon_count", 128'(tr_rcon.size()), 128'(10));
                    for (int i = 0; i < 10 && i < tr_rcon.size(); i++) begin
                        check($sformatf("rcon%0d", i), 128'(tr_rcon[i]), 128'(rcon_tab[i]));
                        check($sformatf("exp_in%0d", i), tr_key[i], e.sched[i]);
                    end
                    for (int a = 0; a < 16; a++) begin
                        rk_addr = 4'(a);
                        #0.2;
                        if (a <= 10) check($sformatf("rk%0d", a), rk_data, e.sched[a]);
                        else check($sformatf("rk_oob%0d", a), rk_data, 128'h0);
                        if (e.kat && a == 1) check("kat_rk1", rk_data, e.kat1);
                        if (e.kat && a == 10) check("kat_rk10", rk_data, e.kat10);
                    end
                end
                tr_rcon.delete();
                tr_key.delete();
                kv_exp = 1;
            end
            if (have_s && c == s_cyc) kv_exp = 0;
        end
    end

    task automatic wait_to(input int target);
        while (cyc < target) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] key, input bit kat,
                            input logic [127:0] k1, input logic [127:0] k10);
        exp_t e;
        if (!have_s || cyc >= s_cyc + LAT + 1) begin
            e.sched     = ref_sched(key);
            e.start_cyc = cyc;
            e.kat       = kat;
            e.kat1      = k1;
            e.kat10     = k10;
            sb.push_back(e);
            have_s = 1;
            s_cyc  = cyc;
        end
        start  = 1'b1;
        key_in = key;
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] Fips1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] Fips10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Zero1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Zero10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    initial begin
        int s0, gap, off;
        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_keys_vld", 128'(keys_vld), 128'(0));
        check("rst_exp_in", exp_in, 128'h0);
        check("rst_exp_rcon", 128'(exp_rcon), 128'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_to(cyc + 2);

        // FIPS key with ignored re-starts, then a back-to-back start right after done.
        s0 = cyc;
        do_start(FipsKey, 1'b1, Fips1, Fips10);
        wait_to(s0 + 5);
        do_start(128'h0, 1'b0, '0, '0);
        wait_to(s0 + 20);
        do_start(128'h0, 1'b0, '0, '0);
        wait_to(s0 + LAT + 1);
        do_start({$urandom, $urandom, $urandom, $urandom}, 1'b0, '0, '0);
        wait_to(s_cyc + LAT + 4);

        // Abort by reset mid-expansion, then expand the all-zero key.
        s0 = cyc;
        do_start(FipsKey, 1'b0, '0, '0);
        wait_to(s0 + 9);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 128'(busy), 128'(0));
        check("arst_keys_vld", 128'(keys_vld), 128'(0));
        have_s = 0;
        kv_exp = 0;
        sb.delete();
        tr_rcon.delete();
        tr_key.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_to(cyc + 1);
        do_start(128'h0, 1'b1, Zero1, Zero10);
        wait_to(s_cyc + LAT + 2);

        // Random keys, random gaps, random ignored starts while busy.
        for (int i = 0; i < 6; i++) begin
            s0 = cyc;
            do_start({$urandom, $urandom, $urandom, $urandom}, 1'b0, '0, '0);
            off = $urandom_range(1, LAT);
            wait_to(s0 + off);
            do_start({$urandom, $urandom, $urandom, $urandom}, 1'b0, '0, '0);
            gap = $urandom_range(0, 6);
            wait_to(s0 + LAT + 1 + gap);
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        check("sb_drained", 128'(sb.size()), 128'(0));
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
